// File: rtl/buffer_burst_reader_if.sv
// Handshake bundle between the burst reader, its source FIFO read port and the downstream consumer.
interface buffer_burst_reader_if #(
  parameter int unsigned N = 32,
  parameter int unsigned L = 8
);
  logic         start;
  logic [L-1:0] burst_len;
  logic         buf_empty;
  logic         buf_pull_en;
  logic [N-1:0] buf_pull_val;
  logic [N-1:0] out_val;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic [L-1:0] words_left;

  modport slave (
    input  start, burst_len, buf_empty, buf_pull_val, out_ready,
    output buf_pull_en, out_val, out_valid, busy, done, words_left
  );

  modport master (
    output start, burst_len, buf_empty, buf_pull_val, out_ready,
    input  buf_pull_en, out_val, out_valid, busy, done, words_left
  );
endinterface

// File: rtl/buffer_burst_reader.sv
// Pulls a programmed number of words from a FIFO read port and presents each
// on a valid/ready handshake; pulses done when the burst completes.
module buffer_burst_reader #(
  parameter int unsigned N = 32,
  parameter int unsigned L = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pwr_off_i,
  buffer_burst_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PULL = 3'd1,
    CAPT = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic         pull_en_q, pull_en_d;
  logic [N-1:0] out_val_q, out_val_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [L-1:0] words_left_q, words_left_d;

  // State and registered outputs; power-off behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || pwr_off_i) begin
      state_q      <= IDLE;
      pull_en_q    <= 1'b0;
      out_val_q    <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      pull_en_q    <= pull_en_d;
      out_val_q    <= out_val_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      words_left_q <= words_left_d;
    end
  end

  // pull_en is registered, so it is decided one cycle ahead of the PULL cycle
  // it appears in. Only this block pulls, so a non-empty buffer stays non-empty.
  always_comb begin
    state_d      = state_q;
    pull_en_d    = 1'b0;
    out_val_d    = out_val_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    words_left_d = words_left_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          words_left_d = bus.burst_len;
          busy_d       = 1'b1;
          if (bus.burst_len == L'(0)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = PULL;
            pull_en_d = !bus.buf_empty;
          end
        end
      end
      PULL: begin
        if (pull_en_q) begin
          state_d = CAPT;
        end else begin
          pull_en_d = !bus.buf_empty;
        end
      end
      CAPT: begin
        out_val_d   = bus.buf_pull_val;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d  = 1'b0;
          words_left_d = words_left_q - L'(1);
          if (words_left_q == L'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = PULL;
            pull_en_d = !bus.buf_empty;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.buf_pull_en = pull_en_q;
  assign bus.out_val     = out_val_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.words_left  = words_left_q;

  // Never pull from an empty buffer.
  a_no_underrun: assert property (@(posedge clk_i) disable iff (rst_i || pwr_off_i)
    !(bus.buf_pull_en && bus.buf_empty));

endmodule
